pong_score_keeper: RTL and testbench
====================================

Name: pong_score_keeper

Overview:
- Tracks both players' Pong scores as two-digit BCD values.
- Detects game over at a parameterised winning score.
- Multiplexes the two scores onto the Go board's pair of seven-segment digits.
- Sits directly upstream of the binary-to-7-segment decoders: digit_tens and digit_ones each feed one decoder instance.
- point_p1 and point_p2 come from the ball/paddle game logic.

Parameters:
- WIN_SCORE, 11, decimal score that ends the game; legal range 1..99.
- ALT_CYCLES, 25000000, clock cycles each player's score is displayed before alternating (1 s at 25 MHz); minimum 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- point_p1  input  1  single-cycle pulse: player 1 scored
- point_p2  input  1  single-cycle pulse: player 2 scored
- restart  input  1  single-cycle pulse: clear scores, start new game
- digit_tens  output  4  BCD tens digit of currently displayed score
- digit_ones  output  4  BCD ones digit of currently displayed score
- blank_tens  output  1  high when displayed tens digit is 0 (leading-zero blanking)
- showing_p2  output  1  0 = displayed score is player 1's, 1 = player 2's
- game_over  output  1  high while in GAME_OVER state
- winner  output  1  valid when game_over: 0 = player 1, 1 = player 2

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Both scores 00.
  - State PLAY; game_over=0, winner=0, showing_p2=0.
  - Alternation counter 0.
  - Resulting outputs: digit_tens=0, digit_ones=0, blank_tens=1.
- Score registers: per player, tens[3:0] and ones[3:0], always valid BCD (0..9 each).
- BCD increment:
  - ones<9: ones+1.
  - ones==9: ones=0, tens+1.
  - No binary intermediate; no value above 99 can occur because WIN_SCORE<=99 stops play first.
- State PLAY:
  - point_p1 increments player 1's score; point_p2 increments player 2's score.
  - Both pulses in the same cycle increment both scores in that cycle.
  - If the post-increment score equals WIN_SCORE, the next state is GAME_OVER. The transition happens on the same edge as the increment, so game_over rises together with the final score.
  - Both players reaching WIN_SCORE on the same edge: winner=0 (player 1 priority).
- State GAME_OVER:
  - point_p1 and point_p2 are ignored; scores are frozen.
  - Alternation stops; showing_p2 is forced to winner on the transition edge and held there.
  - Leaves only on restart or reset.
- restart, from any state:
  - Next edge: scores 00, state PLAY, game_over=0, winner=0, showing_p2=0, alternation counter 0.
  - restart has priority over point pulses in the same cycle; those pulses are dropped.
- Alternation:
  - In PLAY, the counter counts 0..ALT_CYCLES-1.
  - On the edge where the counter is at ALT_CYCLES-1, the counter wraps to 0 and showing_p2 toggles.
  - Scoring does not disturb the counter.
- Output path:
  - digit_tens and digit_ones are combinational selects of the registered scores by showing_p2.
  - blank_tens = (digit_tens==0).
  - Latency: a point pulse in cycle N is visible on the digit outputs in cycle N+1 when that player is displayed.
- Mid-game reset behaves identically to restart.
- Pulses held high for several cycles count once per cycle; deglitching and edge-detection are upstream responsibilities.

Test Plan:
- Reset, then 9 pulses on point_p1 with ALT_CYCLES=8 -> player 1 reads tens=0, ones=9, blank_tens=1 while showing_p2=0; showing_p2 toggles every 8 cycles; player 2 reads 00.
- Tenth point_p1 pulse -> player 1 score wraps to tens=1, ones=0, blank_tens=0 when player 1 is displayed.
- WIN_SCORE=11: player 1 reaches 11 -> game_over=1, winner=0 on the same edge; showing_p2 forced to 0 and held for 3×ALT_CYCLES; further point_p1/point_p2 pulses leave digits at 1,1.
- Both players at 10, point_p1 and point_p2 in the same cycle -> both scores 11, game_over=1, winner=0.
- restart asserted in the same cycle as point_p2 during PLAY with p2=5 -> next cycle p2=00, p1=00, showing_p2=0, counter restarted.
- During GAME_OVER with winner=1, assert reset -> all outputs return to reset values; play resumes and increments normally.

Source files
------------

// File: rtl/pong_score_keeper.sv
// Pong score keeper: two BCD scores, game-over detection at WIN_SCORE, and
// time-multiplexed display of one player's score on a pair of 7-seg digits.
module pong_score_keeper #(
    parameter int WIN_SCORE  = 11,        // 1..99
    parameter int ALT_CYCLES = 25000000   // >= 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       restart,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_ones,
    output logic       blank_tens,
    output logic       showing_p2,
    output logic       game_over,
    output logic       winner
);

    localparam int              CW      = (ALT_CYCLES > 2) ? $clog2(ALT_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(ALT_CYCLES - 1);
    localparam logic [7:0]      WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic {
        PLAY      = 1'b0,
        GAME_OVER = 1'b1
    } state_t;

    // Scores kept as {tens, ones}, each nibble always 0..9.
    state_t          state_q, state_d;
    logic [7:0]      p1_q, p1_d;
    logic [7:0]      p2_q, p2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            show_q, show_d;
    logic            winner_q, winner_d;

    logic [7:0]      p1_inc, p2_inc;
    logic            p1_win, p2_win;

    // Decimal increment straight on the digits; no value above 99 is reachable.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        else
            return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // Next-state: restart beats everything; PLAY scores and alternates; GAME_OVER freezes.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        cnt_d    = cnt_q;
        show_d   = show_q;
        winner_d = winner_q;

        p1_inc = bcd_inc(p1_q);
        p2_inc = bcd_inc(p2_q);
        p1_win = point_p1 && (p1_inc == WIN_BCD);
        p2_win = point_p2 && (p2_inc == WIN_BCD);

        if (restart) begin
            state_d  = PLAY;
            p1_d     = 8'h00;
            p2_d     = 8'h00;
            cnt_d    = '0;
            show_d   = 1'b0;
            winner_d = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (point_p1) p1_d = p1_inc;
                    if (point_p2) p2_d = p2_inc;

                    if (cnt_q == CNT_MAX) begin
                        cnt_d  = '0;
                        show_d = ~show_q;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                    end

                    // Player 1 wins a simultaneous finish; display locks to the winner.
                    if (p1_win || p2_win) begin
                        state_d  = GAME_OVER;
                        winner_d = !p1_win;
                        show_d   = !p1_win;
                        cnt_d    = cnt_q;
                    end
                end
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= PLAY;
            p1_q     <= 8'h00;
            p2_q     <= 8'h00;
            cnt_q    <= '0;
            show_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            cnt_q    <= cnt_d;
            show_q   <= show_d;
            winner_q <= winner_d;
        end
    end

    // Display mux feeding the two 7-seg decoders.
    always_comb begin
        digit_tens = show_q ? p2_q[7:4] : p1_q[7:4];
        digit_ones = show_q ? p2_q[3:0] : p1_q[3:0];
        blank_tens = (digit_tens == 4'd0);
    end

    assign showing_p2 = show_q;
    assign game_over  = (state_q == GAME_OVER);
    assign winner     = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with WIN_SCORE=11, ALT_CYCLES=8.
module tb_pong_score_keeper;

    localparam int ALT = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] digit_tens, digit_ones;
    logic       blank_tens, showing_p2, game_over, winner;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;   // edges since last reset/restart; sets the expected display phase

    pong_score_keeper #(.WIN_SCORE(11), .ALT_CYCLES(ALT)) dut (
        .clock      (clock),
        .reset      (reset),
        .point_p1   (point_p1),
        .point_p2   (point_p2),
        .restart    (restart),
        .digit_tens (digit_tens),
        .digit_ones (digit_ones),
        .blank_tens (blank_tens),
        .showing_p2 (showing_p2),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset || restart) cyc = 0;
        else                  cyc++;
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic a, input logic b, input int n);
        point_p1 = a;
        point_p2 = b;
        tick_n(n);
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    function automatic logic exp_show();
        return logic'((cyc / ALT) % 2);
    endfunction

    task automatic chk_digits(input string tag, input logic [3:0] t, input logic [3:0] o);
        chk({tag, ".tens"},  {4'd0, digit_tens}, {4'd0, t});
        chk({tag, ".ones"},  {4'd0, digit_ones}, {4'd0, o});
        chk({tag, ".blank"}, {7'd0, blank_tens}, {7'd0, (t == 4'd0)});
    endtask

    initial begin
        // Reset values
        tick_n(2);
        chk_digits("rst", 4'd0, 4'd0);
        chk("rst.show", {7'd0, showing_p2}, 8'd0);
        chk("rst.go",   {7'd0, game_over},  8'd0);
        chk("rst.win",  {7'd0, winner},     8'd0);
        reset = 1'b0;

        // Nine held p1 points; display has toggled to p2 after 8 edges
        pulse(1'b1, 1'b0, 9);
        chk("alt9.show", {7'd0, showing_p2}, {7'd0, exp_show()});
        chk_digits("p2_00", 4'd0, 4'd0);
        tick_n(6);
        chk("alt15.show", {7'd0, showing_p2}, 8'd1);
        tick();
        chk("alt16.show", {7'd0, showing_p2}, 8'd0);
        chk_digits("p1_09", 4'd0, 4'd9);

        // Tenth point: BCD carry
        pulse(1'b1, 1'b0, 1);
        chk_digits("p1_10", 4'd1, 4'd0);

        // p2 up to 10 (cyc 27 -> p2 displayed)
        pulse(1'b0, 1'b1, 10);
        chk("p2_10.show", {7'd0, showing_p2}, 8'd1);
        chk_digits("p2_10", 4'd1, 4'd0);
        chk("p2_10.go", {7'd0, game_over}, 8'd0);

        // Simultaneous finish at 11-11: player 1 wins, display forced to p1
        pulse(1'b1, 1'b1, 1);
        chk("tie.go",   {7'd0, game_over},  8'd1);
        chk("tie.win",  {7'd0, winner},     8'd0);
        chk("tie.show", {7'd0, showing_p2}, 8'd0);
        chk_digits("tie", 4'd1, 4'd1);

        // Frozen for 3 alternation periods despite pulses
        pulse(1'b1, 1'b1, 3 * ALT);
        chk("frz.show", {7'd0, showing_p2}, 8'd0);
        chk("frz.go",   {7'd0, game_over},  8'd1);
        chk_digits("frz", 4'd1, 4'd1);

        // Restart (with a dropped p2 pulse), then p1 wins alone
        restart = 1'b1; point_p2 = 1'b1;
        tick();
        restart = 1'b0; point_p2 = 1'b0;
        chk("rs1.go",   {7'd0, game_over},  8'd0);
        chk("rs1.show", {7'd0, showing_p2}, 8'd0);
        chk_digits("rs1", 4'd0, 4'd0);
        pulse(1'b1, 1'b0, 10);
        chk("p1_10b.go",   {7'd0, game_over},  8'd0);
        chk("p1_10b.show", {7'd0, showing_p2}, 8'd1);
        pulse(1'b1, 1'b0, 1);
        chk("p1win.go",   {7'd0, game_over},  8'd1);
        chk("p1win.win",  {7'd0, winner},     8'd0);
        chk("p1win.show", {7'd0, showing_p2}, 8'd0);
        chk_digits("p1win", 4'd1, 4'd1);

        // Restart, p2 reaches 5, then restart collides with a p2 pulse
        restart = 1'b1;
        tick();
        restart = 1'b0;
        pulse(1'b0, 1'b1, 5);
        tick_n(3);
        chk("p2_05.show", {7'd0, showing_p2}, 8'd1);
        chk_digits("p2_05", 4'd0, 4'd5);
        restart = 1'b1; point_p2 = 1'b1;
        tick();
        restart = 1'b0; point_p2 = 1'b0;
        chk("rs2.show", {7'd0, showing_p2}, 8'd0);
        chk("rs2.go",   {7'd0, game_over},  8'd0);
        chk_digits("rs2", 4'd0, 4'd0);
        tick_n(7);
        chk("rs2c7.show", {7'd0, showing_p2}, 8'd0);
        tick();
        chk("rs2c8.show", {7'd0, showing_p2}, 8'd1);
        chk_digits("rs2_p2", 4'd0, 4'd0);

        // p2 wins: display locked to p2
        pulse(1'b0, 1'b1, 11);
        chk("p2win.go",   {7'd0, game_over},  8'd1);
        chk("p2win.win",  {7'd0, winner},     8'd1);
        chk("p2win.show", {7'd0, showing_p2}, 8'd1);
        chk_digits("p2win", 4'd1, 4'd1);
        tick_n(10);
        chk("p2hold.show", {7'd0, showing_p2}, 8'd1);

        // Reset out of GAME_OVER, then play resumes
        reset = 1'b1;
        tick();
        chk("rst2.go",   {7'd0, game_over},  8'd0);
        chk("rst2.win",  {7'd0, winner},     8'd0);
        chk("rst2.show", {7'd0, showing_p2}, 8'd0);
        chk_digits("rst2", 4'd0, 4'd0);
        reset = 1'b0;
        pulse(1'b1, 1'b0, 1);
        chk("resume.go", {7'd0, game_over}, 8'd0);
        chk_digits("resume", 4'd0, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
